// File: rtl/stage_sample_output.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : stage_sample_output                                        |
// | Description : Mono sample FIFO feeding an I2S serializer. Each sample is |
// |               sent on both channels, MSB first, with the one-slot I2S     |
// |               delay. The bit clock is divided down from i_Clock.          |
// |               Optional sticky overflow/underflow flags are compiled only  |
// |               when OCTANE_OUTPUT_STATUS_EN is defined.                    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module stage_sample_output #(
    parameter int CLOCK_DIVIDER = 4,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic        i_Clock,
    input  logic        i_Reset_n,
    input  logic        i_SampleReady,
    input  logic [15:0] i_Sample,
    input  logic        i_ClearStatus,
    output logic        o_BitClock,
    output logic        o_LeftRightClock,
    output logic        o_SerialData,
    output logic [4:0]  o_FifoLevel,
    output logic        o_Overflow,
    output logic        o_Underflow
);

    localparam int         c_PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [7:0] c_DIV_LAST = 8'(CLOCK_DIVIDER - 1);
    localparam logic [4:0] c_DEPTH    = 5'(FIFO_DEPTH);

    logic [7:0]         r_div;
    logic               r_bclk;
    logic [4:0]         r_slot;
    logic [15:0]        r_word;
    logic               r_lrclk;
    logic               r_sdata;
    logic [15:0]        r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [4:0]         r_count;

    logic        w_div_wrap;
    logic        w_fall;
    logic        w_frame_start;
    logic        w_pop;
    logic        w_full;
    logic        w_push;
    logic        w_overflow_evt;
    logic        w_underflow_evt;
    logic [4:0]  w_slot_next;
    logic [3:0]  w_bit_idx;
    logic [15:0] w_word_next;

    // Falling bit-clock edges drive the slot counter; slot 31->0 starts a frame.
    assign w_div_wrap      = (r_div == c_DIV_LAST);
    assign w_fall          = w_div_wrap & r_bclk;
    assign w_frame_start   = w_fall & (r_slot == 5'd31);

    // Pop is evaluated before push, so a full FIFO can accept on a pop cycle.
    // There is no bypass: a push into an empty FIFO never reaches the word
    // that is being loaded in the same cycle.
    assign w_pop           = w_frame_start & (r_count != 5'd0);
    assign w_underflow_evt = w_frame_start & (r_count == 5'd0);
    assign w_full          = (r_count == c_DEPTH);
    assign w_push          = i_SampleReady & (~w_full | w_pop);
    assign w_overflow_evt  = i_SampleReady & w_full & ~w_pop;

    // Both channel halves use bit (15 - s[3:0]), which gives the one-slot delay.
    assign w_slot_next     = r_slot + 5'd1;
    assign w_bit_idx       = 4'd15 - w_slot_next[3:0];
    assign w_word_next     = w_frame_start ? (w_pop ? r_mem[r_rd_ptr] : 16'h0000) : r_word;

    // Bit-clock divider: toggle o_BitClock each time the counter wraps.
    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            r_div  <= 8'd0;
            r_bclk <= 1'b0;
        end else if (w_div_wrap) begin
            r_div  <= 8'd0;
            r_bclk <= ~r_bclk;
        end else begin
            r_div  <= r_div + 8'd1;
        end
    end

    // Slot counter and serial outputs; they only change on a bit-clock fall.
    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            r_slot  <= 5'd31;
            r_word  <= 16'h0000;
            r_lrclk <= 1'b0;
            r_sdata <= 1'b0;
        end else if (w_fall) begin
            r_slot  <= w_slot_next;
            r_word  <= w_word_next;
            r_lrclk <= (w_slot_next >= 5'd15) && (w_slot_next <= 5'd30);
            r_sdata <= w_word_next[w_bit_idx];
        end
    end

    // FIFO pointers and occupancy; the count doubles as the level output.
    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= 5'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 5'd1;
                2'b01:   r_count <= r_count - 5'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge i_Clock) begin
        if (i_Reset_n && w_push) begin
            r_mem[r_wr_ptr] <= i_Sample;
        end
    end

    assign o_BitClock       = r_bclk;
    assign o_LeftRightClock = r_lrclk;
    assign o_SerialData     = r_sdata;
    assign o_FifoLevel      = r_count;

`ifdef OCTANE_OUTPUT_STATUS_EN
    logic r_accepted;
    logic r_overflow;
    logic r_underflow;

    // Sticky flags: a new event wins over a simultaneous clear. Underflow is
    // only reported once the stream has actually started.
    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            r_accepted  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_accepted <= 1'b1;
            end
            r_overflow  <= w_overflow_evt | (r_overflow & ~i_ClearStatus);
            r_underflow <= (w_underflow_evt & r_accepted) | (r_underflow & ~i_ClearStatus);
        end
    end

    assign o_Overflow  = r_overflow;
    assign o_Underflow = r_underflow;
`else
    logic w_unused_status;
    assign w_unused_status = i_ClearStatus | w_overflow_evt | w_underflow_evt;
    assign o_Overflow      = 1'b0;
    assign o_Underflow     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stage_sample_output.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_stage_sample_output                                     |
// | Description : Self-checking bench for stage_sample_output. A monitor     |
// |               deserializes the I2S stream and compares each frame with a |
// |               scoreboard queue of expected words, and checks level and   |
// |               status flags against a small FIFO model.                   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_stage_sample_output;

    localparam int CD    = 4;
    localparam int DEPTH = 4;

    logic        i_Clock = 1'b0;
    logic        i_Reset_n;
    logic        i_SampleReady;
    logic [15:0] i_Sample;
    logic        i_ClearStatus;
    logic        o_BitClock;
    logic        o_LeftRightClock;
    logic        o_SerialData;
    logic [4:0]  o_FifoLevel;
    logic        o_Overflow;
    logic        o_Underflow;

    stage_sample_output #(
        .CLOCK_DIVIDER (CD),
        .FIFO_DEPTH    (DEPTH)
    ) u_dut (
        .i_Clock          (i_Clock),
        .i_Reset_n        (i_Reset_n),
        .i_SampleReady    (i_SampleReady),
        .i_Sample         (i_Sample),
        .i_ClearStatus    (i_ClearStatus),
        .o_BitClock       (o_BitClock),
        .o_LeftRightClock (o_LeftRightClock),
        .o_SerialData     (o_SerialData),
        .o_FifoLevel      (o_FifoLevel),
        .o_Overflow       (o_Overflow),
        .o_Underflow      (o_Underflow)
    );

    always #5 i_Clock = ~i_Clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor / model state
    logic [15:0] mq [$];
    logic [15:0] sb_q [$];
    int          rx_slot = 31;
    bit          frame_open = 0;
    logic [15:0] rx_left, rx_right, m_word;
    bit          m_acc = 0, m_of = 0, m_uf = 0, m_fall = 0;
    bit          m_set_of, m_set_uf;
    logic        prev_bclk = 1'b0, prev_lr = 1'b0, prev_sd = 1'b0;
    logic        s_rdy, s_clr, s_rst_n;
    logic [15:0] s_smp, sb_exp;

    // Monitor: sample inputs at the edge, check outputs 1ns later.
    always @(posedge i_Clock) begin
        s_rdy   = i_SampleReady;
        s_smp   = i_Sample;
        s_clr   = i_ClearStatus;
        s_rst_n = i_Reset_n;
        #1;
        if (!s_rst_n) begin
            check("reset_outputs", 32'({o_BitClock, o_LeftRightClock, o_SerialData,
                                        o_FifoLevel, o_Overflow, o_Underflow}), 32'd0);
            mq.delete();
            sb_q.delete();
            rx_slot    = 31;
            frame_open = 0;
            m_acc = 0; m_of = 0; m_uf = 0; m_fall = 0;
            prev_bclk = 1'b0; prev_lr = 1'b0; prev_sd = 1'b0;
        end else begin
            m_fall   = prev_bclk && !o_BitClock;
            m_set_of = 0;
            m_set_uf = 0;
            if (m_fall) begin
                rx_slot = (rx_slot + 1) % 32;
                if (rx_slot == 0) begin
                    if (mq.size() == 0) begin
                        m_word = 16'h0000;
                        if (m_acc) m_set_uf = 1;
                    end else begin
                        m_word = mq.pop_front();
                    end
                    frame_open = 1;
                end
                check("lrclk", 32'(o_LeftRightClock), 32'(rx_slot >= 15 && rx_slot <= 30));
                if (frame_open) begin
                    if (rx_slot < 16) rx_left[15 - rx_slot]  = o_SerialData;
                    else              rx_right[31 - rx_slot] = o_SerialData;
                    if (rx_slot == 31) begin
                        check("frame_model_left", 32'(rx_left), 32'(m_word));
                        check("frame_model_right", 32'(rx_right), 32'(m_word));
                        if (sb_q.size() > 0) begin
                            sb_exp = sb_q.pop_front();
                            check("frame_sb_left", 32'(rx_left), 32'(sb_exp));
                            check("frame_sb_right", 32'(rx_right), 32'(sb_exp));
                        end
                    end
                end
            end else begin
                check("serial_hold", 32'({o_LeftRightClock, o_SerialData}), 32'({prev_lr, prev_sd}));
            end
            if (s_rdy) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back(s_smp);
                    m_acc = 1;
                end else begin
                    m_set_of = 1;
                end
            end
            m_of = m_set_of | (m_of & !s_clr);
            m_uf = m_set_uf | (m_uf & !s_clr);
            check("fifo_level", 32'(o_FifoLevel), 32'(mq.size()));
`ifdef OCTANE_OUTPUT_STATUS_EN
            check("overflow_flag", 32'(o_Overflow), 32'(m_of));
            check("underflow_flag", 32'(o_Underflow), 32'(m_uf));
`else
            check("overflow_tied", 32'(o_Overflow), 32'd0);
            check("underflow_tied", 32'(o_Underflow), 32'd0);
`endif
            prev_bclk = o_BitClock;
            prev_lr   = o_LeftRightClock;
            prev_sd   = o_SerialData;
        end
    end

    task automatic tick();
        @(posedge i_Clock);
        #2;
    endtask

    task automatic push_one(input logic [15:0] v);
        i_SampleReady = 1'b1;
        i_Sample      = v;
        tick();
        i_SampleReady = 1'b0;
    endtask

    // Wait until the monitor has just seen the bit-clock fall into slot target.
    task automatic wait_slot(input int target);
        bit hit = 0;
        for (int n = 0; n < 64 * CD * 32 && !hit; n++) begin
            tick();
            if (m_fall && rx_slot == target) hit = 1;
        end
        if (!hit) begin
            checks++;
            errors++;
            $display("FAIL wait_slot: got timeout expected slot %0d", target);
        end
    endtask

    // Release reset and check bit-clock timing and the first serial bit.
    task automatic release_and_time(input bit do_push, input logic [15:0] smp);
        logic [15:0] first_word;
        first_word    = do_push ? smp : 16'h0000;
        i_Reset_n     = 1'b1;
        i_ClearStatus = 1'b0;
        for (int k = 0; k < 3 * CD; k++) begin
            if (k == 1 && do_push) begin
                i_SampleReady = 1'b1;
                i_Sample      = smp;
            end else begin
                i_SampleReady = 1'b0;
            end
            if (k == 1) sb_q.push_back(first_word);
            tick();
            check("bitclock_phase", 32'(o_BitClock), 32'(((k + 1) / CD) % 2));
            if (k < 2 * CD - 1)
                check("sdata_before_first_bit", 32'(o_SerialData), 32'd0);
            if (k == 2 * CD - 1) begin
                check("first_bit", 32'(o_SerialData), 32'(first_word[15]));
                check("first_lrclk", 32'(o_LeftRightClock), 32'd0);
            end
        end
        i_SampleReady = 1'b0;
    endtask

    typedef struct {
        bit          push;
        logic [15:0] sample;
        bit          clr;
        logic [15:0] exp_word;
    } vec_t;

    vec_t tbl [7];

    initial begin
        // Per frame: word expected from this frame, sample pushed during it.
        tbl[0] = '{push: 1'b1, sample: 16'h7FFE, clr: 1'b0, exp_word: 16'h8001};
        tbl[1] = '{push: 1'b1, sample: 16'h1234, clr: 1'b0, exp_word: 16'h7FFE};
        tbl[2] = '{push: 1'b1, sample: 16'hFFFF, clr: 1'b0, exp_word: 16'h1234};
        tbl[3] = '{push: 1'b0, sample: 16'h0000, clr: 1'b0, exp_word: 16'hFFFF};
        tbl[4] = '{push: 1'b0, sample: 16'h0000, clr: 1'b1, exp_word: 16'h0000};
        tbl[5] = '{push: 1'b1, sample: 16'h0F0F, clr: 1'b0, exp_word: 16'h0000};
        tbl[6] = '{push: 1'b0, sample: 16'h0000, clr: 1'b1, exp_word: 16'h0F0F};

        i_Reset_n     = 1'b0;
        i_SampleReady = 1'b0;
        i_Sample      = 16'h0000;
        i_ClearStatus = 1'b0;
        repeat (3) tick();

        // Reset release, A5C3 pushed in cycle 1, then 8001 during that frame.
        release_and_time(1'b1, 16'hA5C3);
        push_one(16'h8001);

        for (int i = 0; i < 7; i++) begin
            wait_slot(0);
            sb_q.push_back(tbl[i].exp_word);
            i_SampleReady = tbl[i].push;
            i_Sample      = tbl[i].sample;
            i_ClearStatus = tbl[i].clr;
            tick();
            i_SampleReady = 1'b0;
            i_ClearStatus = 1'b0;
        end

        // Underflow set coinciding with a clear: the set must win.
        wait_slot(31);
        repeat (2 * CD - 1) tick();
        i_ClearStatus = 1'b1;
        tick();
        i_ClearStatus = 1'b0;
        sb_q.push_back(16'h0000);
`ifdef OCTANE_OUTPUT_STATUS_EN
        check("uf_set_wins", 32'(o_Underflow), 32'd1);
`else
        check("uf_set_wins", 32'(o_Underflow), 32'd0);
`endif

        // Five pushes into a 4-deep FIFO: last one dropped.
        push_one(16'h0011);
        push_one(16'h0022);
        push_one(16'h0033);
        push_one(16'h0044);
        push_one(16'h0055);
        check("level_full", 32'(o_FifoLevel), 32'd4);
`ifdef OCTANE_OUTPUT_STATUS_EN
        check("overflow_set", 32'(o_Overflow), 32'd1);
`else
        check("overflow_set", 32'(o_Overflow), 32'd0);
`endif

        // Push exactly on the frame-start pop edge while full.
        wait_slot(31);
        repeat (2 * CD - 1) tick();
        push_one(16'h0066);
        check("level_pop_push", 32'(o_FifoLevel), 32'd4);
        sb_q.push_back(16'h0011);
        i_ClearStatus = 1'b1;
        tick();
        i_ClearStatus = 1'b0;
        check("overflow_cleared", 32'(o_Overflow), 32'd0);
        wait_slot(0); sb_q.push_back(16'h0022);
        wait_slot(0); sb_q.push_back(16'h0033);
        wait_slot(0); sb_q.push_back(16'h0044);
        wait_slot(0); sb_q.push_back(16'h0066);
        wait_slot(0); sb_q.push_back(16'h0000);

        // Reset mid-frame at slot 7 with three samples queued.
        push_one(16'hA001);
        push_one(16'hA002);
        push_one(16'hA003);
        wait_slot(7);
        check("level_before_reset", 32'(o_FifoLevel), 32'd3);
        i_Reset_n     = 1'b0;
        i_SampleReady = 1'b1;
        i_Sample      = 16'hBEEF;
        tick();
        check("reset_level", 32'(o_FifoLevel), 32'd0);
        check("reset_serial", 32'({o_BitClock, o_LeftRightClock, o_SerialData}), 32'd0);
        repeat (2) tick();
        i_SampleReady = 1'b0;
        release_and_time(1'b0, 16'h0000);

        // No underflow before the first accepted sample.
        wait_slot(0);
        check("no_uf_before_push", 32'(o_Underflow), 32'd0);
        push_one(16'h5A5A);
        wait_slot(0);
        sb_q.push_back(16'h5A5A);
        wait_slot(0);
        sb_q.push_back(16'h0000);
`ifdef OCTANE_OUTPUT_STATUS_EN
        check("uf_after_stream", 32'(o_Underflow), 32'd1);
`else
        check("uf_after_stream", 32'(o_Underflow), 32'd0);
`endif
        i_ClearStatus = 1'b1;
        tick();
        i_ClearStatus = 1'b0;
        tick();
        check("uf_cleared", 32'(o_Underflow), 32'd0);
        wait_slot(31);
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
